// File: rtl/ft_pkg.sv
// Shared encodings and constants for the Fibonacci/timer run-mode controller.
package ft_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN_F = 2'd1,
    RUN_T = 2'd2,
    HOLD  = 2'd3
  } state_t;

  localparam int PROG_W       = 3;
  localparam int BASE_DIV_DEF = 8;

  localparam int LED_TIM  = 5;
  localparam int LED_FIB  = 4;
  localparam int LED_HOLD = 3;
endpackage

// File: rtl/tick_prescaler.sv
// Programmable tick divider: one tick every BASE_DIV << shift cycles while running.
module tick_prescaler #(
  parameter int BASE_DIV = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       run,
  input  logic [2:0] shift,
  output logic       tick
);
  localparam int CW = $clog2(BASE_DIV) + 7;

  logic [CW-1:0] cnt;
  logic [CW:0]   per;
  logic [CW-1:0] lim;

  // Period needs one more bit than the counter; P-1 always fits back in CW bits.
  assign per  = (CW+1)'(BASE_DIV) << shift;
  assign lim  = CW'(per - (CW+1)'(1));
  assign tick = run && (cnt == lim);

  always_ff @(posedge clk) begin
    if (!rst)      cnt <= '0;
    else if (clr)  cnt <= '0;
    else if (run)  cnt <= tick ? '0 : cnt + CW'(1);
  end
endmodule

// File: rtl/fib_timer_ctrl.sv
// Run-mode controller: latches speed, runs one datapath at a time, freezes on stop/done.
module fib_timer_ctrl
  import ft_pkg::*;
#(
  parameter int BASE_DIV = BASE_DIV_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_f,
  input  logic              start_t,
  input  logic              stop_f_t,
  input  logic              update,
  input  logic [PROG_W-1:0] prog,
  input  logic              fib_done,
  input  logic              tim_done,
  output logic              fib_clr,
  output logic              tim_clr,
  output logic              fib_en,
  output logic              tim_en,
  output logic              sel,
  output logic [5:0]        led
);
  state_t            state, state_nx;
  logic [PROG_W-1:0] prog_q;
  logic              sel_q, first;
  logic              load_prog, enter_f, enter_t;
  logic              running, tick;

  always_comb begin
    state_nx  = state;
    load_prog = 1'b0;
    enter_f   = 1'b0;
    enter_t   = 1'b0;
    case (state)
      IDLE, HOLD: begin
        // Start beats update; update beats stop.
        if (start_f) begin
          state_nx = RUN_F;
          enter_f  = 1'b1;
        end else if (start_t) begin
          state_nx = RUN_T;
          enter_t  = 1'b1;
        end else if (update) begin
          state_nx  = IDLE;
          load_prog = 1'b1;
        end else if (stop_f_t) begin
          state_nx = IDLE;
        end
      end
      RUN_F:   if (stop_f_t || fib_done) state_nx = HOLD;
      RUN_T:   if (stop_f_t || tim_done) state_nx = HOLD;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      prog_q <= '0;
      sel_q  <= 1'b0;
      first  <= 1'b0;
    end else begin
      state <= state_nx;
      first <= enter_f | enter_t;
      if (load_prog)          prog_q <= prog;
      if (enter_f | enter_t)  sel_q  <= enter_t;
    end
  end

  assign running = (state == RUN_F) || (state == RUN_T);

  tick_prescaler #(.BASE_DIV(BASE_DIV)) u_presc (
    .clk   (clk),
    .rst   (rst),
    .clr   (enter_f | enter_t),
    .run   (running),
    .shift (prog_q),
    .tick  (tick)
  );

  assign fib_clr = (state == RUN_F) && first;
  assign tim_clr = (state == RUN_T) && first;
  assign fib_en  = (state == RUN_F) && tick;
  assign tim_en  = (state == RUN_T) && tick;
  assign sel     = sel_q;

  always_comb begin
    led           = '0;
    led[LED_TIM]  = (state == RUN_T);
    led[LED_FIB]  = (state == RUN_F);
    led[LED_HOLD] = (state == HOLD);
    led[2:0]      = prog_q;
  end
endmodule

// File: tb/tb_fib_timer_ctrl.sv
// Scoreboard bench: cycle-count reference model predicts every output cycle.
module tb_fib_timer_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start_f = 0, start_t = 0, stop_f_t = 0, update = 0;
  logic [2:0] prog = 3'd0;
  logic       fib_done = 0, tim_done = 0;
  logic       fib_clr, tim_clr, fib_en, tim_en, sel;
  logic [5:0] led;

  int errors = 0;
  int checks = 0;

  fib_timer_ctrl #(.BASE_DIV(8)) dut (
    .clk(clk), .rst(rst), .start_f(start_f), .start_t(start_t),
    .stop_f_t(stop_f_t), .update(update), .prog(prog),
    .fib_done(fib_done), .tim_done(tim_done),
    .fib_clr(fib_clr), .tim_clr(tim_clr), .fib_en(fib_en), .tim_en(tim_en),
    .sel(sel), .led(led)
  );

  always #5 clk = ~clk;

  // Reference model: mode 0 idle, 1 fib run, 2 timer run, 3 hold.
  // k counts cycles since run entry (1 = first run cycle); ticks land on multiples of P.
  int       m_mode = 0;
  int       m_prog = 0;
  int       m_sel  = 0;
  int       m_k    = 0;
  int       m_cyc  = 0;
  logic [10:0] exp_q[$];
  int          cyc_q[$];

  always @(posedge clk) begin
    logic [10:0] e;
    int p;
    bit run_f, run_t, was_run;
    m_cyc++;
    was_run = (m_mode == 1 || m_mode == 2);
    if (!rst) begin
      m_mode = 0; m_prog = 0; m_sel = 0; m_k = 0;
    end else begin
      case (m_mode)
        0, 3: begin
          if (start_f)      begin m_mode = 1; m_sel = 0; m_k = 1; end
          else if (start_t) begin m_mode = 2; m_sel = 1; m_k = 1; end
          else if (update)  begin m_mode = 0; m_prog = int'(prog); end
          else if (stop_f_t) m_mode = 0;
        end
        1: if (stop_f_t || fib_done) m_mode = 3; else m_k++;
        2: if (stop_f_t || tim_done) m_mode = 3; else m_k++;
        default: m_mode = 0;
      endcase
    end
    if (was_run && !rst) m_k = m_k; // run-to-run continuation handled above
    p = 8 << m_prog;
    run_f = (m_mode == 1);
    run_t = (m_mode == 2);
    e[10] = run_f && (m_k == 1);
    e[9]  = run_t && (m_k == 1);
    e[8]  = run_f && (m_k % p == 0);
    e[7]  = run_t && (m_k % p == 0);
    e[6]  = (m_sel != 0);
    e[5]  = run_t;
    e[4]  = run_f;
    e[3]  = (m_mode == 3);
    e[2:0] = 3'(m_prog);
    exp_q.push_back(e);
    cyc_q.push_back(m_cyc);
  end

  // Monitor: every cycle the DUT presents a full output word to compare.
  always @(negedge clk) begin
    logic [10:0] act, e;
    int c;
    act = {fib_clr, tim_clr, fib_en, tim_en, sel, led};
    if (exp_q.size() == 0) begin
      if (m_cyc > 0) begin
        errors++; checks++;
        $display("FAIL scoreboard_empty cycle=%0d actual=%b required=entry", m_cyc, act);
      end
    end else begin
      e = exp_q.pop_front();
      c = cyc_q.pop_front();
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL outputs cycle=%0d actual{fclr,tclr,fen,ten,sel,led}=%b required=%b", c, act, e);
      end
    end
  end

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(logic sf, logic st, logic sp, logic up, logic [2:0] pg);
    start_f = sf; start_t = st; stop_f_t = sp; update = up; prog = pg;
    cyc(1);
    start_f = 0; start_t = 0; stop_f_t = 0; update = 0;
  endtask

  initial begin
    // Reset and ignored stop in IDLE
    rst = 0; cyc(3); rst = 1; cyc(2);
    drive(0, 0, 1, 0, 3'd0); cyc(2);
    // Fibonacci run, P = 64
    drive(0, 0, 0, 1, 3'b011);
    drive(1, 0, 0, 0, 3'd0); cyc(200);
    // Stop, then timer
    drive(0, 0, 1, 0, 3'd0); cyc(70);
    drive(0, 1, 0, 0, 3'd0); cyc(30);
    drive(0, 0, 1, 0, 3'd0);
    drive(0, 0, 1, 0, 3'd0);
    // Priority
    drive(1, 1, 0, 0, 3'd0); cyc(20);
    drive(0, 0, 1, 0, 3'd0);
    // Done and reprogram
    drive(0, 1, 0, 0, 3'd0); cyc(70);
    tim_done = 1; cyc(1); tim_done = 0; cyc(5);
    drive(0, 0, 0, 1, 3'b101);
    drive(1, 0, 0, 0, 3'd0); cyc(600);
    // Ignored update mid-run, then mid-run reset
    drive(0, 0, 0, 1, 3'b111); cyc(300);
    rst = 0; cyc(1); rst = 1; cyc(50);
    // Start and update together from HOLD: start wins
    drive(0, 1, 0, 0, 3'd0); cyc(10);
    drive(0, 0, 1, 0, 3'd0);
    drive(1, 0, 0, 1, 3'b110); cyc(40);
    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      start_f  = ($urandom_range(0, 99) < 2);
      start_t  = ($urandom_range(0, 99) < 2);
      stop_f_t = ($urandom_range(0, 99) < 1);
      update   = ($urandom_range(0, 99) < 3);
      prog     = 3'($urandom_range(0, 3));
      fib_done = ($urandom_range(0, 199) < 1);
      tim_done = ($urandom_range(0, 199) < 1);
      rst      = !($urandom_range(0, 999) < 2);
      cyc(1);
    end
    start_f = 0; start_t = 0; stop_f_t = 0; update = 0;
    fib_done = 0; tim_done = 0; rst = 1;
    cyc(3);
    @(negedge clk); #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d required=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
